// File: rtl/array_multiplier_controller.sv
// Multicycle RV32M multiply unit: registers operand magnitudes, lets a combinational
// array settle for LATENCY_CYCLES, then restores the sign and selects the result word.

module array_multiplier #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   multiplicand,
  input  logic [DATA_WIDTH-1:0]   multiplier,
  output logic [2*DATA_WIDTH-1:0] product
);

  always_comb begin
    product = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (multiplier[i]) begin
        product = product + ({{DATA_WIDTH{1'b0}}, multiplicand} << i);
      end
    end
  end

endmodule

// state   | meaning
// IDLE    | no operation in flight, ready for a new one
// COMPUTE | latched magnitudes drive the array, counter runs down to 0
// DONE    | result_o valid; a new operation may be accepted this cycle
module array_multiplier_controller #(
  parameter int DATA_WIDTH     = 32,
  parameter int LATENCY_CYCLES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  data_valid_i,
  input  logic [DATA_WIDTH-1:0] operand_A_i,
  input  logic [DATA_WIDTH-1:0] operand_B_i,
  input  logic [1:0]            operation_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  data_valid_o
);

  localparam int CNT_W = (LATENCY_CYCLES > 1) ? $clog2(LATENCY_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        count;
  logic [DATA_WIDTH-1:0]   mag_a, mag_b, result_q;
  logic [1:0]              op_q;
  logic                    negate_q;
  logic                    valid_q;
  logic [2*DATA_WIDTH-1:0] prod, prod_signed;
  logic                    accept, sign_a, sign_b, last_cycle;

  assign ready_o    = ((state == IDLE) || (state == DONE)) && !stall_i;
  assign accept     = data_valid_i && ready_o && !flush_i;
  assign sign_a     = operand_A_i[DATA_WIDTH-1] && ((operation_i == 2'b01) || (operation_i == 2'b10));
  assign sign_b     = operand_B_i[DATA_WIDTH-1] && (operation_i == 2'b01);
  assign last_cycle = (state == COMPUTE) && (count == '0);

  array_multiplier #(.DATA_WIDTH(DATA_WIDTH)) u_array (
    .multiplicand (mag_a),
    .multiplier   (mag_b),
    .product      (prod)
  );

  assign prod_signed = negate_q ? (~prod + (2*DATA_WIDTH)'(1)) : prod;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else if (!stall_i) begin
      case (state)
        IDLE:    if (accept) state_nxt = COMPUTE;
        COMPUTE: if (count == '0) state_nxt = DONE;
        DONE:    state_nxt = accept ? COMPUTE : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count    <= '0;
      mag_a    <= '0;
      mag_b    <= '0;
      op_q     <= '0;
      negate_q <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (flush_i) begin
      count   <= '0;
      valid_q <= 1'b0;
    end else if (!stall_i) begin
      valid_q <= last_cycle;
      if (last_cycle) begin
        result_q <= (op_q == 2'b00) ? prod_signed[DATA_WIDTH-1:0]
                                    : prod_signed[2*DATA_WIDTH-1:DATA_WIDTH];
      end
      if (accept) begin
        // The most negative value's magnitude still fits as an unsigned N-bit number.
        mag_a    <= sign_a ? (~operand_A_i + DATA_WIDTH'(1)) : operand_A_i;
        mag_b    <= sign_b ? (~operand_B_i + DATA_WIDTH'(1)) : operand_B_i;
        negate_q <= sign_a ^ sign_b;
        op_q     <= operation_i;
        count    <= CNT_W'(LATENCY_CYCLES - 1);
      end else if ((state == COMPUTE) && (count != '0)) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign result_o     = result_q;
  assign data_valid_o = valid_q;

endmodule

// File: tb/tb_array_multiplier_controller.sv
// Directed bench for array_multiplier_controller with a per-cycle reference model
// built from 64-bit arithmetic and a latency countdown.

module tb_array_multiplier_controller;

  localparam int LAT = 2;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        stall_i, flush_i, data_valid_i;
  logic [31:0] operand_A_i, operand_B_i;
  logic [1:0]  operation_i;
  logic        ready_o, data_valid_o;
  logic [31:0] result_o;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc_cnt  = 0;

  array_multiplier_controller #(.DATA_WIDTH(32), .LATENCY_CYCLES(LAT)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .data_valid_i (data_valid_i),
    .operand_A_i  (operand_A_i),
    .operand_B_i  (operand_B_i),
    .operation_i  (operation_i),
    .ready_o      (ready_o),
    .result_o     (result_o),
    .data_valid_o (data_valid_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc_cnt);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc_cnt);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00:   p = ua * ub;
      2'b01:   p = sa * sb;
      2'b10:   p = sa * longint'(ub);
      default: p = ua * ub;
    endcase
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Reference model: an accepted op produces its result LAT un-stalled edges later.
  int          m_rem = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend = '0;
  logic        exp_ready;

  always @(negedge clk_i) begin
    if (!rst_n_i) begin
      m_rem    = 0;
      m_valid  = 1'b0;
      m_result = '0;
    end else begin
      exp_ready = (m_rem == 0) && !stall_i;
      chk1("cmp_ready", ready_o, exp_ready);
      chk1("cmp_valid", data_valid_o, m_valid);
      chk32("cmp_result", result_o, m_result);
      if (flush_i) begin
        m_rem   = 0;
        m_valid = 1'b0;
      end else if (!stall_i) begin
        m_valid = (m_rem == 1);
        if (m_rem == 1) m_result = m_pend;
        if (m_rem > 0) m_rem--;
        if (data_valid_i && exp_ready) begin
          m_rem  = LAT;
          m_pend = ref_result(operation_i, operand_A_i, operand_B_i);
        end
      end
    end
  end

  // Called just after a posedge; returns just after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bit got = 1'b0;
    data_valid_i = 1'b1;
    operation_i  = op;
    operand_A_i  = a;
    operand_B_i  = b;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      got = ready_o;
      @(posedge clk_i);
      #1;
      if (got) break;
    end
    data_valid_i = 1'b0;
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: ready_o never high, expected acceptance");
    end
  endtask

  task automatic wait_dv();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_i);
      if (data_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL dv_timeout: data_valid_o never high, expected a result pulse");
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int t0;
    issue(op, a, b);
    t0 = cyc_cnt;
    wait_dv();
    chk32(name, result_o, exp);
    chk32({name, "_lat"}, 32'(cyc_cnt - t0), 32'(LAT));
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    rst_n_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0; data_valid_i = 1'b0;
    operation_i = '0; operand_A_i = '0; operand_B_i = '0;
    repeat (3) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    @(negedge clk_i);
    chk1("reset_ready", ready_o, 1'b1);
    chk1("reset_valid", data_valid_o, 1'b0);
    chk32("reset_result", result_o, 32'h0);
    @(posedge clk_i); #1;

    chk32("ref_mul", ref_result(2'b00, 32'd7, 32'hFFFFFFFD), 32'hFFFFFFEB);
    chk32("ref_mulh", ref_result(2'b01, 32'h80000000, 32'h80000000), 32'h40000000);
    chk32("ref_mulhsu", ref_result(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    chk32("ref_mulhu", ref_result(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);

    // MUL 7 * -3 with cycle-exact timing
    issue(2'b00, 32'd7, 32'hFFFFFFFD);
    @(negedge clk_i);
    chk1("mul_c1_valid", data_valid_o, 1'b0);
    chk1("mul_c1_ready", ready_o, 1'b0);
    @(negedge clk_i);
    chk1("mul_c2_valid", data_valid_o, 1'b0);
    chk1("mul_c2_ready", ready_o, 1'b0);
    @(negedge clk_i);
    chk1("mul_c3_valid", data_valid_o, 1'b1);
    chk32("mul_c3_result", result_o, 32'hFFFFFFEB);
    chk1("mul_c3_ready", ready_o, 1'b1);
    @(negedge clk_i);
    chk1("mul_c4_valid", data_valid_o, 1'b0);
    @(posedge clk_i); #1;

    run_op("mulh_min_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op("mulhsu_m1_m1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
    run_op("mulhu_max_max", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("mulh_min_one", 2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF);
    run_op("mulh_zero_neg", 2'b01, 32'h00000000, 32'hFFFFFFFF, 32'h00000000);

    // stall for 3 edges during COMPUTE
    issue(2'b00, 32'd6, 32'd7);
    t0 = cyc_cnt;
    stall_i = 1'b1;
    repeat (3) begin
      @(negedge clk_i);
      chk1("stall_c_ready", ready_o, 1'b0);
      @(posedge clk_i); #1;
    end
    stall_i = 1'b0;
    wait_dv();
    chk32("stall_c_result", result_o, 32'd42);
    chk32("stall_c_lat", 32'(cyc_cnt - t0), 32'(LAT + 3));
    @(posedge clk_i); #1;

    // stall for 2 edges while in DONE
    issue(2'b00, 32'd11, 32'd3);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    stall_i = 1'b1;
    @(negedge clk_i);
    chk1("stall_d1_valid", data_valid_o, 1'b1);
    chk1("stall_d1_ready", ready_o, 1'b0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk1("stall_d2_valid", data_valid_o, 1'b1);
    chk1("stall_d2_ready", ready_o, 1'b0);
    @(posedge clk_i); #1;
    stall_i = 1'b0;
    @(negedge clk_i);
    chk1("stall_d3_valid", data_valid_o, 1'b1);
    chk32("stall_d3_result", result_o, 32'd33);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk1("stall_d4_valid", data_valid_o, 1'b0);
    @(posedge clk_i); #1;

    // flush in COMPUTE
    issue(2'b00, 32'd9, 32'd9);
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    @(negedge clk_i);
    chk1("flush_ready", ready_o, 1'b1);
    repeat (4) begin
      chk1("flush_no_valid", data_valid_o, 1'b0);
      chk32("flush_result_kept", result_o, 32'd33);
      @(negedge clk_i);
    end
    @(posedge clk_i); #1;

    // async reset mid-COMPUTE
    issue(2'b00, 32'd5, 32'd5);
    rst_n_i = 1'b0;
    #1;
    chk1("areset_valid", data_valid_o, 1'b0);
    chk32("areset_result", result_o, 32'h0);
    chk1("areset_ready", ready_o, 1'b1);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    run_op("restart", 2'b00, 32'd100, 32'd100, 32'd10000);

    // back-to-back: second op issued during DONE
    issue(2'b00, 32'd3, 32'd5);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    data_valid_i = 1'b1;
    operation_i  = 2'b11;
    operand_A_i  = 32'h00010000;
    operand_B_i  = 32'h00010000;
    @(negedge clk_i);
    chk1("b2b_first_valid", data_valid_o, 1'b1);
    chk32("b2b_first_result", result_o, 32'd15);
    chk1("b2b_done_ready", ready_o, 1'b1);
    t1 = cyc_cnt;
    @(posedge clk_i); #1;
    data_valid_i = 1'b0;
    wait_dv();
    chk32("b2b_second_result", result_o, 32'h00000001);
    chk32("b2b_spacing", 32'(cyc_cnt - t1), 32'(LAT + 1));
    @(posedge clk_i); #1;

    // request held through COMPUTE is taken only in DONE
    issue(2'b00, 32'd2, 32'd3);
    data_valid_i = 1'b1;
    operation_i  = 2'b00;
    operand_A_i  = 32'd4;
    operand_B_i  = 32'd5;
    @(negedge clk_i);
    chk1("held_busy_ready", ready_o, 1'b0);
    wait_dv();
    chk32("held_first_result", result_o, 32'd6);
    t1 = cyc_cnt;
    @(posedge clk_i); #1;
    data_valid_i = 1'b0;
    wait_dv();
    chk32("held_second_result", result_o, 32'd20);
    chk32("held_spacing", 32'(cyc_cnt - t1), 32'(LAT + 1));
    @(posedge clk_i); #1;

    repeat (3) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
